// File: rtl/cic_decim_ctrl.sv
// Purpose : sequencer for a CIC decimator (integrator enables per sample, comb enable per R samples).
// Latency : integ_ena same cycle as accept; comb_ena 1 cycle after window close; out_valid COMB_LAT after comb_ena.
// Backpr. : only the window-closing sample stalls while the previous output is unconsumed.
//
// Ports
//   i_clock, i_reset_n          clock (rising edge), asynchronous active-low reset
//   i_cfg_rate, i_cfg_load      decimation rate R and its load strobe (IDLE only)
//   o_cfg_err                   1-cycle pulse after a rejected load
//   i_start, i_stop             begin filtering / stop and drain the pending output
//   i_in_valid, o_in_ready      input sample handshake
//   o_integ_ena, o_comb_ena     integrator enable / comb enable pulse
//   o_dp_clear                  1-cycle datapath clear, issued with start
//   o_dec_phase                 samples accepted in the current window
//   o_out_valid, i_out_ready    decimated output handshake
//   o_busy                      controller not idle
module cic_decim_ctrl #(
   parameter int RATE_W       = 8,
   parameter int DEFAULT_RATE = 3,
   parameter int COMB_LAT     = 1
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [RATE_W-1:0] i_cfg_rate,
   input  logic              i_cfg_load,
   output logic              o_cfg_err,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_integ_ena,
   output logic              o_comb_ena,
   output logic              o_dp_clear,
   output logic [RATE_W-1:0] o_dec_phase,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] LAT_RELOAD = 4'(COMB_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [RATE_W-1:0] r_rate;
   logic [RATE_W-1:0] r_phase;
   logic              r_hold_full;
   logic [3:0]        r_lat_cnt;
   logic              r_comb_ena;
   logic              r_out_valid;
   logic              r_cfg_err;

   logic              w_consume;
   logic              w_last;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_dp_clear;
   logic              w_fire;

   assign w_consume = r_out_valid & i_out_ready;
   assign w_last    = (r_phase == (r_rate - RATE_W'(1)));
   assign w_accept  = w_in_ready & i_in_valid;

   // out_valid rises COMB_LAT cycles after the comb_ena pulse; with a latency
   // of one the pulse itself is the trigger, otherwise the countdown is.
   assign w_fire = r_comb_ena ? (COMB_LAT == 1) : (r_lat_cnt == 4'd1);

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_dp_clear  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_dp_clear  = 1'b1;
            end
         end
         S_RUN: begin
            // A same-cycle consume frees the output slot for the closing sample.
            w_in_ready = !i_stop & !(r_hold_full & w_last & !w_consume);
            if (i_stop) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_hold_full) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rate      <= RATE_W'(DEFAULT_RATE);
         r_phase     <= '0;
         r_hold_full <= 1'b0;
         r_lat_cnt   <= 4'd0;
         r_comb_ena  <= 1'b0;
         r_out_valid <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         // Rate only changes between runs so a window never sees two rates.
         if (i_cfg_load && (r_state == S_IDLE) && (i_cfg_rate != '0)) begin
            r_rate <= i_cfg_rate;
         end
         r_cfg_err <= i_cfg_load & ((r_state != S_IDLE) | (i_cfg_rate == '0));

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_phase <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_phase <= w_last ? '0 : (r_phase + RATE_W'(1));
               end
            end
            default: begin
               // Partial window is discarded while draining.
               r_phase <= '0;
            end
         endcase

         r_comb_ena <= w_accept & w_last;

         if (w_accept && w_last) begin
            r_hold_full <= 1'b1;
         end else if (w_consume) begin
            r_hold_full <= 1'b0;
         end

         if (r_comb_ena) begin
            r_lat_cnt <= LAT_RELOAD;
         end else if (r_lat_cnt != 4'd0) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end

         if (w_fire) begin
            r_out_valid <= 1'b1;
         end else if (w_consume) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_cfg_err   = r_cfg_err;
   assign o_in_ready  = w_in_ready;
   assign o_integ_ena = w_accept;
   assign o_comb_ena  = r_comb_ena;
   assign o_dp_clear  = w_dp_clear;
   assign o_dec_phase = r_phase;
   assign o_out_valid = r_out_valid;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Purpose : self-checking bench for cic_decim_ctrl, two instances (COMB_LAT 1 and 3) on shared stimulus.
// Latency : checks every cycle on the falling edge against an event-scheduling model.
// Backpr. : stimulus exercises stalled window-closing samples and same-cycle release.
module tb_cic_decim_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] cfg_rate;
   logic       cfg_load;
   logic       start;
   logic       stop;
   logic       in_valid;
   logic       out_ready;

   logic [1:0] cfg_err;
   logic [1:0] in_ready;
   logic [1:0] integ;
   logic [1:0] comb;
   logic [1:0] dpclr;
   logic [1:0] ov;
   logic [1:0] busy;
   logic [7:0] dphase [2];

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // model state, one entry per instance
   int m_mode [2];      // 0 idle, 1 run, 2 drain
   int m_rate [2];
   int m_cnt [2];
   int m_full [2];
   int m_ov [2];
   int m_rise [2];      // cycle at which out_valid is due to rise
   int m_comb_at [2];   // cycle at which comb_ena is due
   int m_err_at [2];    // cycle at which cfg_err is due

   // observed tallies
   int n_integ [2];
   int n_comb [2];
   int n_hs [2];
   int n_errp [2];
   int last_integ [2];
   int last_comb [2];
   int last_ov_rise [2];
   int p_ov [2];
   int s_integ [2];
   int s_comb [2];
   int s_hs [2];
   int s_errp [2];

   cic_decim_ctrl #(.RATE_W(8), .DEFAULT_RATE(3), .COMB_LAT(1)) dut0 (
      .i_clock(clk), .i_reset_n(rst_n), .i_cfg_rate(cfg_rate), .i_cfg_load(cfg_load),
      .o_cfg_err(cfg_err[0]), .i_start(start), .i_stop(stop), .i_in_valid(in_valid),
      .o_in_ready(in_ready[0]), .o_integ_ena(integ[0]), .o_comb_ena(comb[0]),
      .o_dp_clear(dpclr[0]), .o_dec_phase(dphase[0]), .o_out_valid(ov[0]),
      .i_out_ready(out_ready), .o_busy(busy[0])
   );

   cic_decim_ctrl #(.RATE_W(8), .DEFAULT_RATE(3), .COMB_LAT(3)) dut1 (
      .i_clock(clk), .i_reset_n(rst_n), .i_cfg_rate(cfg_rate), .i_cfg_load(cfg_load),
      .o_cfg_err(cfg_err[1]), .i_start(start), .i_stop(stop), .i_in_valid(in_valid),
      .o_in_ready(in_ready[1]), .o_integ_ena(integ[1]), .o_comb_ena(comb[1]),
      .o_dp_clear(dpclr[1]), .o_dec_phase(dphase[1]), .o_out_valid(ov[1]),
      .i_out_ready(out_ready), .o_busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_mode[k]    = 0;
      m_rate[k]    = 3;
      m_cnt[k]     = 0;
      m_full[k]    = 0;
      m_ov[k]      = 0;
      m_rise[k]    = -1;
      m_comb_at[k] = -1;
      m_err_at[k]  = -1;
   endtask

   task automatic model_cycle();
      for (int k = 0; k < 2; k++) begin
         int  lat;
         int  cons, rdy, acc, cmb, full_now;
         string t;
         lat = (k == 0) ? 1 : 3;
         t   = (k == 0) ? "u0" : "u1";
         if (!rst_n) begin
            model_reset(k);
            chk({t, "_rst_in_ready"}, in_ready[k], 0);
            chk({t, "_rst_integ"},    integ[k],    0);
            chk({t, "_rst_comb"},     comb[k],     0);
            chk({t, "_rst_out_valid"}, ov[k],      0);
            chk({t, "_rst_busy"},     busy[k],     0);
            chk({t, "_rst_phase"},    dphase[k],   0);
            chk({t, "_rst_cfg_err"},  cfg_err[k],  0);
            chk({t, "_rst_dp_clear"}, dpclr[k],    0);
            p_ov[k] = 0;
         end else begin
            if (cyc == m_rise[k]) m_ov[k] = 1;
            cmb  = (cyc == m_comb_at[k]) ? 1 : 0;
            cons = (m_ov[k] != 0 && out_ready) ? 1 : 0;
            rdy  = (m_mode[k] == 1 && !stop &&
                    !(m_full[k] != 0 && m_cnt[k] == m_rate[k] - 1 && cons == 0)) ? 1 : 0;
            acc  = (rdy != 0 && in_valid) ? 1 : 0;

            chk({t, "_in_ready"},  in_ready[k], rdy);
            chk({t, "_integ_ena"}, integ[k],    acc);
            chk({t, "_comb_ena"},  comb[k],     cmb);
            chk({t, "_dp_clear"},  dpclr[k],    (m_mode[k] == 0 && start) ? 1 : 0);
            chk({t, "_dec_phase"}, dphase[k],   m_cnt[k]);
            chk({t, "_out_valid"}, ov[k],       m_ov[k]);
            chk({t, "_busy"},      busy[k],     (m_mode[k] != 0) ? 1 : 0);
            chk({t, "_cfg_err"},   cfg_err[k],  (cyc == m_err_at[k]) ? 1 : 0);

            if (integ[k]) begin n_integ[k]++; last_integ[k] = cyc; end
            if (comb[k])  begin n_comb[k]++;  last_comb[k]  = cyc; end
            if (ov[k] && out_ready) n_hs[k]++;
            if (cfg_err[k]) n_errp[k]++;
            if (ov[k] && p_ov[k] == 0) last_ov_rise[k] = cyc;
            p_ov[k] = ov[k];

            full_now = m_full[k];
            if (cmb != 0) m_rise[k] = cyc + lat;
            if (cons != 0) begin m_ov[k] = 0; m_full[k] = 0; end
            if (cfg_load) begin
               if (m_mode[k] != 0 || cfg_rate == 0) m_err_at[k] = cyc + 1;
               else m_rate[k] = cfg_rate;
            end
            case (m_mode[k])
               0: if (start) begin m_mode[k] = 1; m_cnt[k] = 0; end
               1: begin
                  if (stop) m_mode[k] = 2;
                  else if (acc != 0) begin
                     if (m_cnt[k] == m_rate[k] - 1) begin
                        m_cnt[k] = 0; m_full[k] = 1; m_comb_at[k] = cyc + 1;
                     end else m_cnt[k]++;
                  end
               end
               default: begin
                  m_cnt[k] = 0;
                  if (full_now == 0) m_mode[k] = 0;
               end
            endcase
         end
      end
      cyc++;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         model_cycle();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      for (int k = 0; k < 2; k++) begin
         s_integ[k] = n_integ[k];
         s_comb[k]  = n_comb[k];
         s_hs[k]    = n_hs[k];
         s_errp[k]  = n_errp[k];
      end
   endtask

   task automatic load_rate(input int r);
      cfg_rate = 8'(r); cfg_load = 1'b1; step(1);
      cfg_load = 1'b0; step(1);
   endtask

   task automatic do_start();
      start = 1'b1; step(1);
      start = 1'b0;
   endtask

   task automatic drain_all();
      in_valid = 1'b0; stop = 1'b1; step(1);
      stop = 1'b0; out_ready = 1'b1; step(12);
      chk("drain_idle_u0", busy[0], 0);
      chk("drain_idle_u1", busy[1], 0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         n_integ[k] = 0; n_comb[k] = 0; n_hs[k] = 0; n_errp[k] = 0;
         last_integ[k] = -1; last_comb[k] = -1; last_ov_rise[k] = -1; p_ov[k] = 0;
      end
      rst_n = 1'b0; cfg_rate = 8'd0; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      step(3);
      chk("reset_busy", busy[0], 0);
      chk("reset_phase", dphase[0], 0);
      chk("reset_out_valid", ov[0], 0);
      rst_n = 1'b1;
      step(2);

      // default rate 3, six samples with consuming downstream
      snap();
      do_start();
      in_valid = 1'b1; out_ready = 1'b1; step(6);
      in_valid = 1'b0; step(4);
      chk("t1_integ_count", n_integ[0] - s_integ[0], 6);
      chk("t1_comb_count",  n_comb[0]  - s_comb[0],  2);
      chk("t1_out_count",   n_hs[0]    - s_hs[0],    2);
      chk("t1_comb_after_accept", last_comb[0] - last_integ[0], 1);
      chk("t1_ov_after_comb", last_ov_rise[0] - last_comb[0], 1);
      drain_all();

      // rate 5 load, rejected zero load, rejected load while running
      snap();
      load_rate(5);
      cfg_rate = 8'd0; cfg_load = 1'b1; step(1);
      cfg_load = 1'b0; step(1);
      do_start();
      in_valid = 1'b1; out_ready = 1'b1; step(10);
      in_valid = 1'b0; step(4);
      cfg_rate = 8'd7; cfg_load = 1'b1; step(1);
      cfg_load = 1'b0; step(2);
      chk("t2_integ_count", n_integ[0] - s_integ[0], 10);
      chk("t2_comb_count",  n_comb[0]  - s_comb[0],  2);
      chk("t2_out_count",   n_hs[0]    - s_hs[0],    2);
      chk("t2_err_count_u0", n_errp[0] - s_errp[0], 2);
      chk("t2_err_count_u1", n_errp[1] - s_errp[1], 2);
      drain_all();

      // backpressure at rate 2
      load_rate(2);
      snap();
      do_start();
      out_ready = 1'b0; in_valid = 1'b1; step(6);
      chk("t3_accepts_before_stall", n_integ[0] - s_integ[0], 3);
      chk("t3_stalled_ready", in_ready[0], 0);
      chk("t3_out_pending", ov[0], 1);
      out_ready = 1'b1; #1;
      chk("t3_release_ready", in_ready[0], 1);
      chk("t3_release_integ", integ[0], 1);
      step(1);
      in_valid = 1'b0;
      drain_all();

      // stop with a pending output at rate 4
      load_rate(4);
      do_start();
      out_ready = 1'b0; in_valid = 1'b1; step(5);
      in_valid = 1'b0; step(4);
      chk("t4_phase_before_stop", dphase[0], 1);
      chk("t4_out_pending", ov[0], 1);
      snap();
      stop = 1'b1; step(1);
      stop = 1'b0;
      chk("t4_drain_busy", busy[0], 1);
      step(3);
      chk("t4_drain_hold_busy", busy[0], 1);
      chk("t4_drain_phase", dphase[0], 0);
      out_ready = 1'b1; step(4);
      chk("t4_idle_after_consume", busy[0], 0);
      chk("t4_idle_phase", dphase[0], 0);
      chk("t4_no_extra_comb_u0", n_comb[0] - s_comb[0], 0);
      chk("t4_no_extra_comb_u1", n_comb[1] - s_comb[1], 0);
      step(2);

      // rate 1 on both latencies
      load_rate(1);
      snap();
      do_start();
      in_valid = 1'b1; out_ready = 1'b1; step(12);
      in_valid = 1'b0; step(6);
      chk("t5_integ_u0", n_integ[0] - s_integ[0], 6);
      chk("t5_comb_u0",  n_comb[0]  - s_comb[0],  6);
      chk("t5_integ_u1", n_integ[1] - s_integ[1], 3);
      chk("t5_comb_u1",  n_comb[1]  - s_comb[1],  3);
      chk("t5_ov_lat3",  last_ov_rise[1] - last_comb[1], 3);
      chk("t5_comb_after_accept_u1", last_comb[1] - last_integ[1], 1);
      drain_all();

      // reset while an output is pending, then default rate is back
      load_rate(2);
      do_start();
      out_ready = 1'b0; in_valid = 1'b1; step(5);
      chk("t6_out_pending", ov[0], 1);
      rst_n = 1'b0; #1;
      chk("t6_rst_out_valid", ov[0], 0);
      chk("t6_rst_busy", busy[0], 0);
      chk("t6_rst_in_ready", in_ready[0], 0);
      chk("t6_rst_integ", integ[0], 0);
      chk("t6_rst_phase", dphase[0], 0);
      step(2);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      step(1);
      snap();
      do_start();
      in_valid = 1'b1; step(6);
      in_valid = 1'b0; step(4);
      chk("t6_default_rate_integ", n_integ[0] - s_integ[0], 6);
      chk("t6_default_rate_comb",  n_comb[0]  - s_comb[0],  2);
      drain_all();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
